seg_scan_display: RTL

- Parametrised multi-digit seven-segment scanner for the board display.
- Holds NUM_DIGITS 5-bit glyph codes in a double-buffered register set and time-multiplexes them onto shared active-low cathodes and anodes.
- Adds per-digit blink, decimal point, enable and anti-ghost blanking.
- Feeds the board pins directly; the score/status logic drives it.

---
 rtl/seg_pkg.sv | 17 +
 rtl/seg_glyph_decode.sv | 35 +++
 rtl/seg_scan_display.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared glyph codes and cathode constants for the seven-segment scanner.
package seg_pkg;

  localparam logic [4:0] GLYPH_P      = 5'd10;
  localparam logic [4:0] GLYPH_T      = 5'd11;
  localparam logic [4:0] GLYPH_S      = 5'd12;
  localparam logic [4:0] GLYPH_DASH   = 5'd13;
  localparam logic [4:0] GLYPH_G      = 5'd14;
  localparam logic [4:0] GLYPH_HALF_M = 5'd15;
  localparam logic [4:0] GLYPH_E      = 5'd17;
  localparam logic [4:0] GLYPH_V      = 5'd18;
  localparam logic [4:0] GLYPH_R      = 5'd19;
  localparam logic [4:0] GLYPH_BLANK  = 5'd31;

  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_glyph_decode.sv
// Glyph code to active-low cathodes {G,F,E,D,C,B,A}; unknown codes are blank.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (code)
      5'd0:         seg = 7'h40;
      5'd1:         seg = 7'h79;
      5'd2:         seg = 7'h24;
      5'd3:         seg = 7'h30;
      5'd4:         seg = 7'h19;
      5'd5:         seg = 7'h12;
      5'd6:         seg = 7'h02;
      5'd7:         seg = 7'h78;
      5'd8:         seg = 7'h00;
      5'd9:         seg = 7'h10;
      GLYPH_P:      seg = 7'h0C;
      GLYPH_T:      seg = 7'h07;
      GLYPH_S:      seg = 7'h12;
      GLYPH_DASH:   seg = 7'h3F;
      GLYPH_G:      seg = 7'h42;
      GLYPH_HALF_M: seg = 7'h48;
      GLYPH_E:      seg = 7'h06;
      GLYPH_V:      seg = 7'h41;
      GLYPH_R:      seg = 7'h2F;
      default:      seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment scanner with double-buffered glyphs, blink and
// anti-ghost blanking of the first cycle of every digit slot.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [5*NUM_DIGITS-1:0] glyphs,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int unsigned IdxW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SlotW  = $clog2(REFRESH_DIV);
  localparam int unsigned FrameW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(NUM_DIGITS - 1);
  localparam logic [SlotW-1:0]  SlotLast  = SlotW'(REFRESH_DIV - 1);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(BLINK_FRAMES - 1);

  logic [SlotW-1:0]        slot_q;
  logic [IdxW-1:0]         idx_q;
  logic [FrameW-1:0]       frame_q;
  logic                    blink_q;
  logic [5*NUM_DIGITS-1:0] stage_glyph_q, active_glyph_q;
  logic [NUM_DIGITS-1:0]   stage_dp_q, active_dp_q;
  logic                    pending_q;
  logic [NUM_DIGITS-1:0]   an_q;
  logic [6:0]              seg_q;
  logic                    dp_q, frame_done_q;

  logic                  slot_term, frame_end, lit;
  logic [4:0]            cur_code;
  logic [6:0]            cur_seg;
  logic                  cur_dp, cur_en, cur_blink;
  logic [NUM_DIGITS-1:0] sel;

  assign slot_term = (slot_q == SlotLast);
  assign frame_end = slot_term && (idx_q == IdxLast);

  always_comb begin
    cur_code  = GLYPH_BLANK;
    cur_dp    = 1'b0;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    sel       = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        cur_code  = active_glyph_q[5*i +: 5];
        cur_dp    = active_dp_q[i];
        cur_en    = digit_en[i];
        cur_blink = blink_mask[i];
        sel[i]    = 1'b1;
      end
    end
  end

  // digit_en and blink_mask are live; the glyph data comes from the active bank.
  assign lit = (slot_q != '0) && cur_en && !(cur_blink && blink_q);

  seg_glyph_decode u_decode (
    .code (cur_code),
    .seg  (cur_seg)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q         <= '0;
      idx_q          <= '0;
      frame_q        <= '0;
      blink_q        <= 1'b0;
      stage_glyph_q  <= '1;
      active_glyph_q <= '1;
      stage_dp_q     <= '0;
      active_dp_q    <= '0;
      pending_q      <= 1'b0;
      an_q           <= '1;
      seg_q          <= SEG_OFF;
      dp_q           <= 1'b1;
      frame_done_q   <= 1'b0;
    end else begin
      slot_q <= slot_term ? '0 : slot_q + SlotW'(1);
      if (slot_term) begin
        idx_q <= (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
      end
      frame_done_q <= frame_end;

      if (frame_end) begin
        if (frame_q == FrameLast) begin
          frame_q <= '0;
          blink_q <= ~blink_q;
        end else begin
          frame_q <= frame_q + FrameW'(1);
        end
      end

      // A load landing on the boundary bypasses staging entirely.
      if (frame_end) begin
        if (load) begin
          active_glyph_q <= glyphs;
          active_dp_q    <= dp_in;
        end else if (pending_q) begin
          active_glyph_q <= stage_glyph_q;
          active_dp_q    <= stage_dp_q;
        end
        pending_q <= 1'b0;
      end else if (load) begin
        stage_glyph_q <= glyphs;
        stage_dp_q    <= dp_in;
        pending_q     <= 1'b1;
      end

      an_q  <= lit ? ~sel : '1;
      seg_q <= lit ? cur_seg : SEG_OFF;
      dp_q  <= lit ? ~cur_dp : 1'b1;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = frame_done_q;

endmodule
